// File: rtl/remap_accel_div_pkg.sv
// ============================================================================
// remap_accel_div_pkg : shared types and constants for the remap divider
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package remap_accel_div_pkg;

  localparam int unsigned DIV_DIVIDEND_WIDTH = 22;
  localparam int unsigned DIV_DIVISOR_WIDTH  = 11;
  localparam int unsigned CNT_WIDTH          = $clog2(DIV_DIVIDEND_WIDTH);

  // Quotient reported when the divisor is zero
  localparam logic [DIV_DIVIDEND_WIDTH-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/remap_accel_udiv_step.sv
// ============================================================================
// remap_accel_udiv_step : one restoring-division iteration (combinational)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module remap_accel_udiv_step #(
  parameter int unsigned DIVISOR_WIDTH = 11
) (
  input  logic [DIVISOR_WIDTH:0]   r_in,
  input  logic                     q_msb,
  input  logic [DIVISOR_WIDTH-1:0] d,
  output logic [DIVISOR_WIDTH:0]   r_next,
  output logic                     q_bit
);

  logic [DIVISOR_WIDTH:0] t;
  logic [DIVISOR_WIDTH:0] d_ext;
  logic [DIVISOR_WIDTH:0] diff;
  // R < D keeps the top bit of R at zero, so it never enters the shift
  logic                   r_msb_unused;

  assign r_msb_unused = r_in[DIVISOR_WIDTH];
  assign t            = {r_in[DIVISOR_WIDTH-1:0], q_msb};
  assign d_ext        = {1'b0, d};
  assign diff         = t - d_ext;
  assign q_bit        = (t >= d_ext);
  assign r_next       = q_bit ? diff : t;

endmodule

`default_nettype wire

// File: rtl/remap_accel_udiv_22ns_11ns_seq.sv
// ============================================================================
// remap_accel_udiv_22ns_11ns_seq : iterative unsigned restoring divider
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module remap_accel_udiv_22ns_11ns_seq
  import remap_accel_div_pkg::*;
#(
  parameter int unsigned DIVIDEND_WIDTH = DIV_DIVIDEND_WIDTH,
  parameter int unsigned DIVISOR_WIDTH  = DIV_DIVISOR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ce,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  div_state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_WIDTH-1:0] q_q, q_d;
  logic [DIVISOR_WIDTH:0]    r_q, r_d;
  logic [DIVISOR_WIDTH-1:0]  d_q, d_d;
  logic                      dbz_q, dbz_d;

  logic [DIVISOR_WIDTH:0]    step_r;
  logic                      step_bit;

  remap_accel_udiv_step #(
    .DIVISOR_WIDTH (DIVISOR_WIDTH)
  ) u_step (
    .r_in   (r_q),
    .q_msb  (q_q[DIVIDEND_WIDTH-1]),
    .d      (d_q),
    .r_next (step_r),
    .q_bit  (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    dbz_d   = dbz_q;
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (divisor != '0) begin
              q_d     = dividend;
              d_d     = divisor;
              r_d     = '0;
              cnt_d   = '0;
              dbz_d   = 1'b0;
              state_d = CALC;
            end else begin
              // Zero divisor bypasses the iteration entirely
              q_d     = DBZ_QUOTIENT;
              r_d     = {1'b0, dividend[DIVISOR_WIDTH-1:0]};
              dbz_d   = 1'b1;
              state_d = DONE;
            end
          end
        end
        CALC: begin
          q_d   = {q_q[DIVIDEND_WIDTH-2:0], step_bit};
          r_d   = step_r;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(DIVIDEND_WIDTH - 1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = r_q[DIVISOR_WIDTH-1:0];
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_remap_accel_udiv_22ns_11ns_seq.sv
// ============================================================================
// tb_remap_accel_udiv_22ns_11ns_seq : directed self-checking bench
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_remap_accel_udiv_22ns_11ns_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [21:0] dividend = '0;
  logic [10:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [21:0] quotient;
  logic [10:0] remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  remap_accel_udiv_22ns_11ns_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands for one edge; returns just after the accept edge
  task automatic send(input logic [21:0] a, input logic [10:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges until out_valid; optional in_valid pulse and ce drop window
  task automatic wait_valid(input int pulse_at, input int ce_at, input int ce_len,
                            output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      if (edges == pulse_at) begin
        dividend = 22'd50;
        divisor  = 11'd5;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      ce = !(edges >= ce_at && edges < ce_at + ce_len);
      @(posedge clk);
      #1;
      edges++;
    end
    in_valid = 1'b0;
    ce       = 1'b1;
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_ov_clr"}, out_valid, 0);
    check({tag, "_in_rdy"}, in_ready, 1);
  endtask

  task automatic run_vec(input string tag, input logic [21:0] a, input logic [10:0] b,
                         input logic [21:0] eq, input logic [10:0] er,
                         input logic edbz, input int elat);
    int lat;
    send(a, b);
    wait_valid(-1, -1, 0, lat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, edbz);
    take_result(tag);
  endtask

  initial begin
    int lat;
    int seen;

    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic divide with an ignored operand pulse during CALC, then backpressure
    send(22'd1000, 11'd7);
    wait_valid(3, -1, 0, lat);
    check("basic_lat", lat, 22);
    check("basic_q", quotient, 142);
    check("basic_r", remainder, 6);
    check("basic_dbz", div_by_zero, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_ov", out_valid, 1);
      check("bp_in_rdy", in_ready, 0);
      check("bp_q", quotient, 142);
      check("bp_r", remainder, 6);
    end
    take_result("basic");
    run_vec("after_bp", 22'd50, 11'd5, 22'd10, 11'd0, 1'b0, 22);

    // Extremes and edge values
    run_vec("max_div1", 22'd4194303, 11'd1, 22'd4194303, 11'd0, 1'b0, 22);
    run_vec("max_max", 22'd4194303, 11'd2047, 22'd2049, 11'd0, 1'b0, 22);
    run_vec("small", 22'd5, 11'd2047, 22'd0, 11'd5, 1'b0, 22);
    run_vec("zero_num", 22'd0, 11'd9, 22'd0, 11'd0, 1'b0, 22);

    // Zero divisor: result visible right after the accept edge
    run_vec("dbz", 22'h2ABCD, 11'd0, 22'h3FFFFF, 11'h3CD, 1'b1, 0);
    run_vec("post_dbz", 22'd1000, 11'd7, 22'd142, 11'd6, 1'b0, 22);

    // ce held low for 5 edges mid-calculation
    send(22'd1000, 11'd7);
    wait_valid(-1, 10, 5, lat);
    check("ce_lat", lat, 27);
    check("ce_q", quotient, 142);
    check("ce_r", remainder, 6);
    take_result("ce");

    // Asynchronous reset in the middle of an operation
    send(22'd1000, 11'd7);
    repeat (11) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    check("arst_dbz", div_by_zero, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("arst_no_result", seen, 0);
    check("arst_idle_rdy", in_ready, 1);
    run_vec("post_rst", 22'd100, 11'd3, 22'd33, 11'd1, 1'b0, 22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/remap_accel_udiv_22ns_11ns_seq.md
Name: remap_accel_udiv_22ns_11ns_seq

Overview:
Iterative unsigned restoring divider for the remap accelerator. It is the inverse of the pipelined 11x11 multiply used to form linear pixel addresses: it recovers row (quotient) and column (remainder) from a 22-bit linear index and an 11-bit line width. It has valid/ready handshakes on both the operand and result sides, processes one quotient bit per enabled cycle, and has one operation in flight at a time.

Parameters:
DIVIDEND_WIDTH, 22, dividend and quotient width in bits.
DIVISOR_WIDTH, 11, divisor and remainder width in bits.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
ce  in  1  clock enable; when low, all registers hold their values.
in_valid  in  1  operands present.
in_ready  out  1  block can accept operands.
dividend  in  DIVIDEND_WIDTH  unsigned numerator.
divisor  in  DIVISOR_WIDTH  unsigned denominator.
out_valid  out  1  result present.
out_ready  in  1  downstream accepts the result.
quotient  out  DIVIDEND_WIDTH  floor(dividend/divisor).
remainder  out  DIVISOR_WIDTH  dividend mod divisor.
div_by_zero  out  1  result flag: divisor was 0.

Behaviour:
- Reset (async, reset_n low): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Reset takes effect immediately, including in the middle of an operation; the in-flight operation is discarded and no result is produced.
- ce=0: state, counter, datapath and outputs are frozen, and no handshake completes. in_ready and out_valid hold their current levels.
- State IDLE: in_ready=1. Accept occurs on an edge where ce, in_valid and in_ready are all high.
  - If divisor!=0: latch the dividend into the shift register Q, latch the divisor into D, clear the partial remainder R (width DIVISOR_WIDTH+1), clear the counter, go to CALC.
  - If divisor==0: quotient = all ones, remainder = dividend[DIVISOR_WIDTH-1:0], div_by_zero=1, go to DONE. This path has a latency of 1 edge.
- State CALC: in_ready=0, out_valid=0. On each enabled edge:
  - T = {R[DIVISOR_WIDTH-1:0], Q[MSB]}.
  - If T >= D: R = T - D and the bit shifted into Q's LSB is 1; otherwise R = T and the bit shifted in is 0.
  - Q shifts left by 1.
  - The counter increments. On the edge where the counter reaches DIVIDEND_WIDTH-1 (the 22nd iteration), go to DONE.
- State DONE: out_valid=1, in_ready=0. quotient=Q, remainder=R[DIVISOR_WIDTH-1:0], div_by_zero=0 (except on the zero-divisor path).
  - quotient, remainder and div_by_zero are stable while out_valid is high and out_ready is low.
  - On an enabled edge with out_ready high: go to IDLE and clear out_valid. Output data keeps its last values (don't-care after the handshake).
- Latency: operand accept edge to out_valid high is 22 enabled edges for a nonzero divisor and 1 enabled edge for a zero divisor. Minimum initiation interval is 24 cycles (accept, 22 CALC cycles, 1 DONE cycle with out_ready=1).
- in_valid or new operand values during CALC or DONE are ignored; they are not accepted and not queued.
- Width rules: all arithmetic is unsigned. The compare/subtract is DIVISOR_WIDTH+1 bits wide, and R < D holds after every iteration.
- Edge values: dividend=0 gives quotient 0, remainder 0. divisor=1 gives quotient = dividend, remainder 0. dividend < divisor gives quotient 0, remainder = dividend.

Decomposition:
- Shared package remap_accel_div_pkg holds:
  - a state enum {IDLE, CALC, DONE};
  - localparam CNT_WIDTH = $clog2(DIVIDEND_WIDTH);
  - the divide-by-zero quotient constant (all ones).
- One natural sub-module: remap_accel_udiv_step, a combinational single-iteration unit with inputs R, Q[MSB], D and outputs next R and the quotient bit. The top level holds the FSM, counter and registers.

Test Plan:
- Basic: dividend=1000, divisor=7 -> quotient=142, remainder=6, div_by_zero=0; out_valid rises exactly 22 edges after the accept edge.
- Extremes: 4194303/1 -> q=4194303, r=0. 4194303/2047 -> q=2049, r=0. 5/2047 -> q=0, r=5. 0/9 -> q=0, r=0.
- Zero divisor: dividend=0x2ABCD, divisor=0 -> 1 edge later out_valid=1, quotient=0x3FFFFF, remainder=0x3CD, div_by_zero=1.
- Backpressure and ignored input:
  - out_ready=0 for 10 cycles after out_valid: outputs hold 142/6, and in_ready stays 0.
  - in_valid pulsed with 50/5 during CALC: ignored.
  - After out_ready=1: in_ready=1 the next cycle, and a new 50/5 gives q=10, r=0.
- ce gating: drop ce for 5 cycles midway through CALC on 1000/7 -> out_valid is delayed by exactly 5 cycles and the result is still 142/6.
- Reset mid-operation: assert reset_n low asynchronously (between edges) at iteration 11 -> outputs take reset values immediately. After release, no out_valid appears; in_ready=1; a subsequent 100/3 gives q=33, r=1.
